// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: handshake bundle between the backend and the multi-slot fetch PC generator
interface fetch_pc_gen_if #(
   parameter int XLEN    = 32,
   parameter int FETCH_W = 2
);
   localparam int AW = $clog2(FETCH_W + 1);
   logic                    stall_i;
   logic [AW-1:0]           accept_cnt_i;
   logic                    dec_redir_valid_i;
   logic [XLEN-1:0]         dec_redir_target_i;
   logic                    ex_redir_valid_i;
   logic [XLEN-1:0]         ex_redir_target_i;
   logic [FETCH_W*XLEN-1:0] pc_o;
   logic [FETCH_W-1:0]      pc_valid_o;
   logic                    misalign_err_o;
   logic                    redirect_o;
   modport master (
      output stall_i, accept_cnt_i, dec_redir_valid_i, dec_redir_target_i,
             ex_redir_valid_i, ex_redir_target_i,
      input  pc_o, pc_valid_o, misalign_err_o, redirect_o
   );
   modport slave (
      input  stall_i, accept_cnt_i, dec_redir_valid_i, dec_redir_target_i,
             ex_redir_valid_i, ex_redir_target_i,
      output pc_o, pc_valid_o, misalign_err_o, redirect_o
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: presents FETCH_W consecutive fetch PCs, advances by consumed slots, handles redirects with a bubble
module fetch_pc_gen #(
   parameter int              XLEN            = 32,
   parameter int              FETCH_W         = 2,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h0001_0000,
   parameter int              REDIRECT_BUBBLE = 1
) (
   input logic           clk,
   input logic           rst_n,
   fetch_pc_gen_if.slave bus
);
   localparam int AW = $clog2(FETCH_W + 1);
   localparam logic [0:0] RUN    = 1'b0;
   localparam logic [0:0] BUBBLE = 1'b1;
   logic [XLEN-1:0] base_pc;
   logic [0:0]      state;
   logic [1:0]      cnt;
   logic [AW-1:0]   adv;
   logic            redir;
   logic [XLEN-1:0] tgt;
   assign adv   = (int'(bus.accept_cnt_i) > FETCH_W) ? AW'(FETCH_W) : bus.accept_cnt_i;
   assign redir = bus.ex_redir_valid_i | bus.dec_redir_valid_i;
   assign tgt   = bus.ex_redir_valid_i ? bus.ex_redir_target_i : bus.dec_redir_target_i;
   assign bus.pc_valid_o = {FETCH_W{state == RUN}};
   for (genvar i = 0; i < FETCH_W; i++) begin : g_slot
      assign bus.pc_o[i*XLEN +: XLEN] = base_pc + XLEN'(4 * i);
   end
   // Redirects win over stall and bubble; otherwise RUN advances by clamped accept count and BUBBLE counts down
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_pc            <= RESET_PC;
         state              <= RUN;
         cnt                <= 2'd0;
         bus.redirect_o     <= 1'b0;
         bus.misalign_err_o <= 1'b0;
      end else begin
         bus.redirect_o     <= redir;
         bus.misalign_err_o <= redir & |tgt[1:0];
         if (redir) begin
            base_pc <= {tgt[XLEN-1:2], 2'b00};
            state   <= (REDIRECT_BUBBLE > 0) ? BUBBLE : RUN;
            cnt     <= 2'(REDIRECT_BUBBLE);
         end else if (!bus.stall_i) begin
            if (state == RUN) begin
               base_pc <= base_pc + (XLEN'(adv) << 2);
            end else begin
               cnt <= cnt - 2'd1;
               if (cnt == 2'd1) state <= RUN;
            end
         end
      end
   end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed plus random checks of four fetch_pc_gen configurations against a behavioural model
module tb_fetch_pc_gen;
   localparam logic [15:0] FWP = {4'd1, 4'd4, 4'd2, 4'd2};
   localparam logic [15:0] RBP = {4'd0, 4'd3, 4'd2, 4'd1};
   logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, dv = 1'b0, ev = 1'b0;
   logic [2:0]  acc = 3'd0;
   logic [31:0] dt = 32'd0, et = 32'd0;
   logic [3:0][127:0] pc_obs;
   logic [3:0][3:0]   val_obs;
   logic [3:0]        red_obs, err_obs;
   logic [31:0] m_base[4];
   int          m_bub[4];
   logic        m_red[4], m_err[4];
   int n_assert = 0, n_fail = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : inst
      localparam int FW = int'(FWP[g*4 +: 4]);
      localparam int RB = int'(RBP[g*4 +: 4]);
      localparam int AW = $clog2(FW + 1);
      fetch_pc_gen_if #(.XLEN(32), .FETCH_W(FW)) bus();
      fetch_pc_gen #(.XLEN(32), .FETCH_W(FW), .RESET_PC(32'h0001_0000), .REDIRECT_BUBBLE(RB))
         dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
      assign bus.stall_i            = stall;
      assign bus.accept_cnt_i       = acc[AW-1:0];
      assign bus.dec_redir_valid_i  = dv;
      assign bus.dec_redir_target_i = dt;
      assign bus.ex_redir_valid_i   = ev;
      assign bus.ex_redir_target_i  = et;
      assign pc_obs[g]  = 128'(bus.pc_o);
      assign val_obs[g] = 4'(bus.pc_valid_o);
      assign red_obs[g] = bus.redirect_o;
      assign err_obs[g] = bus.misalign_err_o;
   end
   function automatic int fw_of(int g);
      return int'(FWP[g*4 +: 4]);
   endfunction
   function automatic int rb_of(int g);
      return int'(RBP[g*4 +: 4]);
   endfunction
   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int g = 0; g < 4; g++) begin
         m_base[g] = 32'h0001_0000;
         m_bub[g]  = 0;
         m_red[g]  = 1'b0;
         m_err[g]  = 1'b0;
      end
   endtask
   task automatic model_step();
      for (int g = 0; g < 4; g++) begin
         int fw, aw, a;
         logic [31:0] t;
         fw = fw_of(g);
         aw = (fw == 1) ? 1 : (fw <= 3) ? 2 : 3;
         a  = int'(acc) % (1 << aw);
         if (a > fw) a = fw;
         t  = ev ? et : dt;
         m_red[g] = ev | dv;
         m_err[g] = (ev | dv) && (t % 4 != 0);
         if (ev | dv) begin
            m_base[g] = t - (t % 4);
            m_bub[g]  = rb_of(g);
         end else if (!stall) begin
            if (m_bub[g] > 0) m_bub[g]--;
            else m_base[g] = m_base[g] + 32'(4 * a);
         end
      end
   endtask
   task automatic check_all(string tag);
      for (int g = 0; g < 4; g++) begin
         logic [127:0] ep;
         ep = '0;
         for (int i = 0; i < fw_of(g); i++) ep[i*32 +: 32] = m_base[g] + 32'(4 * i);
         check($sformatf("%s.pc%0d", tag, g), pc_obs[g], ep);
         check($sformatf("%s.valid%0d", tag, g), 128'(val_obs[g]), (m_bub[g] == 0) ? 128'((1 << fw_of(g)) - 1) : 128'd0);
         check($sformatf("%s.redirect%0d", tag, g), 128'(red_obs[g]), 128'(m_red[g]));
         check($sformatf("%s.misalign%0d", tag, g), 128'(err_obs[g]), 128'(m_err[g]));
      end
   endtask
   task automatic step(string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask
   task automatic clear_redir();
      dv = 1'b0;
      ev = 1'b0;
   endtask
   // Directed test plan first, then constrained-random traffic with occasional async resets
   initial begin
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all("reset");
      check("reset_pc_w2", pc_obs[0], {32'h0001_0004, 32'h0001_0000});
      check("reset_valid_w4", 128'(val_obs[2]), 128'hF);
      #1 rst_n = 1'b1;
      acc = 3'd2;
      step("seq1");
      check("seq1_pc", pc_obs[0], {32'h0001_000C, 32'h0001_0008});
      step("seq2");
      step("seq3");
      check("seq3_pc", pc_obs[0], {32'h0001_001C, 32'h0001_0018});
      acc = 3'd1;
      step("partial");
      check("partial_pc", pc_obs[0], {32'h0001_0020, 32'h0001_001C});
      stall = 1'b1;
      acc   = 3'd2;
      step("stall");
      check("stall_pc", pc_obs[0], {32'h0001_0020, 32'h0001_001C});
      dv = 1'b1; dt = 32'h0002_0000;
      ev = 1'b1; et = 32'h0003_0000;
      step("both_redir");
      check("both_redir_pc", pc_obs[0], {32'h0003_0004, 32'h0003_0000});
      check("both_redir_valid", 128'(val_obs[0]), 128'd0);
      check("both_redir_pulse", 128'(red_obs[0]), 128'd1);
      clear_redir();
      stall = 1'b0;
      step("after_bubble");
      check("after_bubble_valid", 128'(val_obs[0]), 128'h3);
      check("after_bubble_pulse", 128'(red_obs[0]), 128'd0);
      ev = 1'b1; et = 32'h0002_0006;
      step("misalign");
      check("misalign_pc", 128'(pc_obs[0][31:0]), 128'h0002_0004);
      check("misalign_err", 128'(err_obs[0]), 128'd1);
      clear_redir();
      step("misalign_clear");
      check("misalign_err_clear", 128'(err_obs[0]), 128'd0);
      ev = 1'b1; et = 32'h0000_4000;
      step("rb2_first");
      clear_redir();
      dv = 1'b1; dt = 32'h0000_5000; acc = 3'd2;
      step("rb2_reload");
      check("rb2_reload_pc", 128'(pc_obs[1][31:0]), 128'h5000);
      check("rb2_reload_valid", 128'(val_obs[1]), 128'd0);
      clear_redir();
      step("rb2_b1");
      check("rb2_b1_valid", 128'(val_obs[1]), 128'd0);
      check("rb2_b1_pc", 128'(pc_obs[1][31:0]), 128'h5000);
      step("rb2_run");
      check("rb2_run_valid", 128'(val_obs[1]), 128'h3);
      check("rb2_run_pc", 128'(pc_obs[1][31:0]), 128'h5000);
      step("rb2_adv");
      check("rb2_adv_pc", 128'(pc_obs[1][31:0]), 128'h5008);
      ev = 1'b1; et = 32'hFFFF_FFF8;
      step("wrap_redir");
      clear_redir();
      acc = 3'd0;
      step("wrap_b1");
      step("wrap_b2");
      step("wrap_b3");
      check("wrap_pc", pc_obs[2], {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8});
      check("wrap_valid", 128'(val_obs[2]), 128'hF);
      acc = 3'd4;
      step("wrap_adv");
      check("wrap_adv_pc", 128'(pc_obs[2][31:0]), 128'h8);
      ev = 1'b1; et = 32'h0000_0100;
      step("pre_rst_redir");
      clear_redir();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      check("async_rst_pc", 128'(pc_obs[2][31:0]), 128'h0001_0000);
      @(posedge clk);
      #1;
      check_all("rst_hold");
      #1 rst_n = 1'b1;
      step("rst_release");
      check("rst_release_valid", 128'(val_obs[2]), 128'hF);
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(99) < 20);
         ev    = ($urandom_range(99) < 8);
         dv    = ($urandom_range(99) < 10);
         et    = $urandom;
         dt    = $urandom;
         acc   = 3'($urandom_range(7));
         step("rnd");
         if ($urandom_range(99) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            check_all("rnd_rst");
            #1 rst_n = 1'b1;
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Parametrised multi-slot fetch PC generator for the superscalar front end; replaces the fixed two-slot next-PC block.
- Each cycle presents FETCH_W consecutive word-aligned PCs to the instruction fetch stage.
- Advances by the number of slots the decode/dispatch side actually consumed (0..FETCH_W).
- Accepts redirects from decode (jal/branch) and execute (jalr/mispredict), with a configurable post-redirect bubble.

Parameters:
XLEN, 32, address width in bits
FETCH_W, 2, fetch slots per cycle (legal 1..4)
RESET_PC, 32'h0001_0000, base PC loaded at reset
REDIRECT_BUBBLE, 1, cycles of invalid fetch after a redirect (legal 0..3)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
stall_i  in  1  backend blocked (RS full / error); forces zero advance
accept_cnt_i  in  $clog2(FETCH_W+1)  slots consumed this cycle, oldest first
dec_redir_valid_i  in  1  decode-stage redirect request
dec_redir_target_i  in  XLEN  decode redirect target
ex_redir_valid_i  in  1  execute-stage redirect request (higher priority)
ex_redir_target_i  in  XLEN  execute redirect target
pc_o  out  FETCH_W*XLEN  slot PCs; slot i occupies bits [i*XLEN +: XLEN]
pc_valid_o  out  FETCH_W  per-slot valid
misalign_err_o  out  1  one-cycle pulse: accepted redirect target had bits [1:0] != 0
redirect_o  out  1  one-cycle pulse: redirect taken this cycle (fetch flush)

Behaviour:
- Registered state: base_pc (XLEN), state (RUN/BUBBLE), bubble counter, misalign_err_o, redirect_o.
- pc_o slot i = base_pc + 4*i, combinational, modulo 2^XLEN (wrap permitted, no flag).
- Reset (async): base_pc=RESET_PC, state=RUN, counter=0, misalign_err_o=0, redirect_o=0. pc_valid_o reads all ones from the first cycle after reset.
- pc_valid_o = all ones in RUN, all zeros in BUBBLE.
- Per-clock priority, highest first:
  1. ex_redir_valid_i: base_pc <= {ex_target[XLEN-1:2],2'b00}; redirect_o<=1; misalign_err_o<=|ex_target[1:0]. Applies regardless of stall_i, state, or a simultaneous dec redirect.
  2. dec_redir_valid_i: same, using dec_redir_target_i.
  3. stall_i=1: base_pc holds; state and counter hold.
  4. RUN, no stall: base_pc <= base_pc + 4*min(accept_cnt_i, FETCH_W). accept_cnt_i=0 holds. Partial accept k keeps unconsumed slots: old slot k becomes new slot 0.
  5. BUBBLE, no stall: base_pc holds; accept_cnt_i ignored; counter decrements; at 1 -> RUN.
- Redirect state effect:
  - REDIRECT_BUBBLE>0: state<=BUBBLE, counter<=REDIRECT_BUBBLE. A redirect during BUBBLE reloads target and restarts the counter.
  - REDIRECT_BUBBLE=0: state stays RUN; new PCs valid the next cycle.
- redirect_o and misalign_err_o are 0 in any cycle without an accepted redirect.
- Latency: redirect at edge N -> target visible on pc_o after edge N. Valid after N+REDIRECT_BUBBLE edges.
- accept_cnt_i > FETCH_W is clamped to FETCH_W.
- The adder is XLEN wide; the shift amount is at most 4*FETCH_W.
- Reset asserted mid-BUBBLE or mid-redirect returns immediately to the reset values above.

Test Plan:
1. Reset, FETCH_W=2, accept_cnt=2 for 3 cycles -> pc_o slots (0x10000,0x10004), (0x10008,0x1000C), (0x10010,0x10014), (0x10018,0x1001C); valid=2'b11.
2. At base 0x10008, accept_cnt=1 -> slots (0x1000C,0x10010). Next cycle stall_i=1 with accept_cnt=2 -> unchanged.
3. dec redirect 0x20000 and ex redirect 0x30000 in the same cycle, REDIRECT_BUBBLE=1 -> base 0x30000, redirect_o=1 for one cycle, valid=00 for 1 cycle, then 11.
4. ex redirect to 0x20006 -> base 0x20004, misalign_err_o=1 for exactly one cycle.
5. REDIRECT_BUBBLE=2: redirect to 0x4000; in the 1st bubble cycle, dec redirect to 0x5000 -> base 0x5000, valid=00 for 2 further cycles, accept_cnt ignored throughout.
6. FETCH_W=4, XLEN=32, base 0xFFFF_FFF8 -> slots 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; accept_cnt=4 -> base 0x8. Assert rst_n mid-bubble -> base 0x10000, valid=1111 after release.
